// File: rtl/led_disp_pkg.sv
// Shared types, widths and the wrap-around source search for the LED display scheduler.
package led_disp_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STEP_W  = 3;
  localparam int unsigned FRAME_W = 16;
  localparam int unsigned MAX_SRC = 8;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW   = 2'd1,
    BLANK  = 2'd2,
    URGENT = 2'd3
  } disp_state_e;

  // First set bit of valid at or after start (start may equal nsrc), wrapping at nsrc.
  function automatic logic [IDX_W-1:0] next_valid_idx(input logic [MAX_SRC-1:0] valid,
                                                      input int unsigned       start,
                                                      input int unsigned       nsrc);
    logic [IDX_W-1:0] idx;
    logic             found;
    int unsigned      cand;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_SRC; i++) begin
      cand = start + i;
      if (cand >= nsrc) cand = cand - nsrc;
      if (i < nsrc && !found && valid[IDX_W'(cand)]) begin
        idx   = IDX_W'(cand);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/led_scan_timer.sv
// Free-running scan divider: digit-step and frame ticks plus the display scan clock.
module led_scan_timer
  import led_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic disp_scan,
  output logic frame_tick_c
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned HALF  = SCAN_DIV / 2;

  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  div_d;
  logic [STEP_W-1:0] step_q;
  logic              step_tick;

  // Tick decode and next divider value.
  always_comb begin
    step_tick    = (div_q == DIV_W'(SCAN_DIV - 1));
    frame_tick_c = step_tick && (step_q == '1);
    div_d        = step_tick ? '0 : div_q + DIV_W'(1);
  end

  // Counters; scan output is registered from the next divider value so it tracks div exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      step_q    <= '0;
      disp_scan <= 1'b1;
    end else begin
      div_q     <= div_d;
      disp_scan <= (div_d < DIV_W'(HALF));
      if (step_tick) step_q <= step_q + STEP_W'(1);
    end
  end

endmodule

// File: rtl/led_display_scheduler.sv
// Shares the hex LED display between rotating debug sources and an urgent message port.
module led_display_scheduler
  import led_disp_pkg::*;
#(
  parameter int unsigned NSRC          = 4,
  parameter int unsigned SCAN_DIV      = 50000,
  parameter int unsigned DWELL_FRAMES  = 512,
  parameter int unsigned BLANK_FRAMES  = 16,
  parameter int unsigned URGENT_FRAMES = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NSRC*DATA_W-1:0]   src_data,
  input  logic [NSRC-1:0]          src_valid,
  input  logic                     auto_mode,
  input  logic                     next_btn,
  input  logic                     urgent_req,
  input  logic [DATA_W-1:0]        urgent_data,
  output logic                     urgent_ack,
  output logic                     disp_scan,
  output logic [DATA_W-1:0]        disp_data,
  output logic                     disp_enable_n,
  output logic [$clog2(NSRC)-1:0]  cur_src
);

  localparam int unsigned SRC_W = $clog2(NSRC);

  disp_state_e        state_q;
  disp_state_e        state_d;
  logic [FRAME_W-1:0] frame_cnt_q;
  logic [FRAME_W-1:0] frame_cnt_d;
  logic [FRAME_W-1:0] frame_cnt_inc;
  logic               advance_q;
  logic               advance_d;
  logic [SRC_W-1:0]   cur_src_d;
  logic [DATA_W-1:0]  disp_data_d;
  logic               disp_enable_n_d;
  logic               urgent_ack_d;
  logic               frame_tick_c;
  logic               any_valid_c;
  logic               urgent_grant_c;
  logic [SRC_W-1:0]   first_idx_c;
  logic [SRC_W-1:0]   next_idx_c;
  logic [SRC_W-1:0]   pick_idx_c;
  logic [DATA_W-1:0]  src_word [NSRC];

  led_scan_timer #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .disp_scan    (disp_scan),
    .frame_tick_c (frame_tick_c)
  );

  // Unpack the flat source bus into words.
  for (genvar g = 0; g < NSRC; g++) begin : g_unpack
    assign src_word[g] = src_data[DATA_W*g +: DATA_W];
  end

  // Source search: inclusive from cur_src (resume) or from cur_src+1 (advance).
  always_comb begin
    any_valid_c    = |src_valid;
    first_idx_c    = SRC_W'(next_valid_idx(MAX_SRC'(src_valid), 32'(cur_src), NSRC));
    next_idx_c     = SRC_W'(next_valid_idx(MAX_SRC'(src_valid), 32'(cur_src) + 32'd1, NSRC));
    pick_idx_c     = advance_q ? next_idx_c : first_idx_c;
    frame_cnt_inc  = frame_cnt_q + FRAME_W'(1);
    urgent_grant_c = frame_tick_c && urgent_req && (state_q != URGENT);
  end

  // Next-state and next-output logic; urgent grant outranks every other transition.
  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    advance_d    = advance_q;
    cur_src_d    = cur_src;
    disp_data_d  = disp_data;
    urgent_ack_d = 1'b0;

    if (urgent_grant_c) begin
      state_d      = URGENT;
      frame_cnt_d  = '0;
      disp_data_d  = urgent_data;
      urgent_ack_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_tick_c && any_valid_c) begin
            state_d     = SHOW;
            frame_cnt_d = '0;
            cur_src_d   = first_idx_c;
            disp_data_d = src_word[first_idx_c];
          end
        end
        SHOW: begin
          if (next_btn) begin
            state_d     = BLANK;
            advance_d   = 1'b1;
            frame_cnt_d = '0;
          end else if (frame_tick_c) begin
            if (!src_valid[cur_src] ||
                (auto_mode && frame_cnt_inc >= FRAME_W'(DWELL_FRAMES))) begin
              state_d     = BLANK;
              advance_d   = 1'b1;
              frame_cnt_d = '0;
            end else begin
              disp_data_d = src_word[cur_src];
              if (auto_mode) frame_cnt_d = frame_cnt_inc;
            end
          end
        end
        BLANK: begin
          if (frame_tick_c) begin
            if (frame_cnt_inc >= FRAME_W'(BLANK_FRAMES)) begin
              frame_cnt_d = '0;
              if (any_valid_c) begin
                state_d     = SHOW;
                cur_src_d   = pick_idx_c;
                disp_data_d = src_word[pick_idx_c];
              end else begin
                state_d     = IDLE;
                disp_data_d = '0;
              end
            end else begin
              frame_cnt_d = frame_cnt_inc;
            end
          end
        end
        URGENT: begin
          if (frame_tick_c) begin
            if (frame_cnt_inc >= FRAME_W'(URGENT_FRAMES)) begin
              state_d     = BLANK;
              advance_d   = 1'b0;
              frame_cnt_d = '0;
            end else begin
              frame_cnt_d = frame_cnt_inc;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    disp_enable_n_d = !((state_d == SHOW) || (state_d == URGENT));
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      frame_cnt_q   <= '0;
      advance_q     <= 1'b0;
      cur_src       <= '0;
      disp_data     <= '0;
      disp_enable_n <= 1'b1;
      urgent_ack    <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      advance_q     <= advance_d;
      cur_src       <= cur_src_d;
      disp_data     <= disp_data_d;
      disp_enable_n <= disp_enable_n_d;
      urgent_ack    <= urgent_ack_d;
    end
  end

endmodule
